// File: rtl/dcpu16_pkg.sv
// Shared constants for the DCPU-16 F-BUS/G-BUS memory arbiter.
// Build option: DCPU16_ARB_RR_EN selects round-robin arbitration.
package dcpu16_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 16;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BUSY_F = 2'd1;
   localparam logic [1:0] ST_BUSY_G = 2'd2;
   localparam logic [1:0] ST_ACK    = 2'd3;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_F    = 2'b01;
   localparam logic [1:0] GNT_G    = 2'b10;

endpackage

// File: rtl/dcpu16_arb_pick.sv
// Combinational winner select between the F-BUS and G-BUS requests.
// Build option: DCPU16_ARB_RR_EN (round-robin), otherwise G over F.
module dcpu16_arb_pick
   import dcpu16_pkg::*;
(
   input  logic       f_stb_i,
   input  logic       g_stb_i,
`ifdef DCPU16_ARB_RR_EN
   input  logic       last_g_i,
`endif
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = GNT_NONE;
      if (f_stb_i && g_stb_i) begin
`ifdef DCPU16_ARB_RR_EN
         gnt_o = last_g_i ? GNT_F : GNT_G;
`else
         gnt_o = GNT_G;
`endif
      end else if (g_stb_i) begin
         gnt_o = GNT_G;
      end else if (f_stb_i) begin
         gnt_o = GNT_F;
      end
   end

endmodule

// File: rtl/dcpu16_arb.sv
// Serialises F-BUS and G-BUS requests onto one single-port memory bus.
// Build option: DCPU16_ARB_RR_EN enables round-robin on simultaneous requests.
module dcpu16_arb
   import dcpu16_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] f_adr,
   input  logic          f_stb,
   input  logic          f_wre,
   input  logic [DW-1:0] f_dto,
   output logic [DW-1:0] f_dti,
   output logic          f_ack,
   input  logic [AW-1:0] g_adr,
   input  logic          g_stb,
   input  logic          g_wre,
   input  logic [DW-1:0] g_dto,
   output logic [DW-1:0] g_dti,
   output logic          g_ack,
   output logic [AW-1:0] m_adr,
   output logic          m_stb,
   output logic          m_wre,
   output logic [DW-1:0] m_dto,
   input  logic [DW-1:0] m_dti,
   input  logic          m_ack,
   output logic [1:0]    m_gnt
);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] m_adr_q, m_adr_d;
   logic [DW-1:0] m_dto_q, m_dto_d;
   logic [DW-1:0] f_dti_q, f_dti_d;
   logic [DW-1:0] g_dti_q, g_dti_d;
   logic          m_stb_q, m_stb_d;
   logic          m_wre_q, m_wre_d;
   logic          f_ack_q, f_ack_d;
   logic          g_ack_q, g_ack_d;
   logic [1:0]    m_gnt_q, m_gnt_d;
   logic [1:0]    pick;

`ifdef DCPU16_ARB_RR_EN
   logic          last_g_q, last_g_d;
`endif

   dcpu16_arb_pick u_pick (
      .f_stb_i  (f_stb),
      .g_stb_i  (g_stb),
`ifdef DCPU16_ARB_RR_EN
      .last_g_i (last_g_q),
`endif
      .gnt_o    (pick)
   );

   always_comb begin
      state_d = state_q;
      m_adr_d = m_adr_q;
      m_dto_d = m_dto_q;
      f_dti_d = f_dti_q;
      g_dti_d = g_dti_q;
      m_stb_d = m_stb_q;
      m_wre_d = m_wre_q;
      m_gnt_d = m_gnt_q;
      f_ack_d = 1'b0;
      g_ack_d = 1'b0;
`ifdef DCPU16_ARB_RR_EN
      last_g_d = last_g_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (pick != GNT_NONE) begin
               m_stb_d = 1'b1;
               m_gnt_d = pick;
`ifdef DCPU16_ARB_RR_EN
               last_g_d = (pick == GNT_G);
`endif
               if (pick == GNT_G) begin
                  m_adr_d = g_adr;
                  m_wre_d = g_wre;
                  m_dto_d = g_dto;
                  state_d = ST_BUSY_G;
               end else begin
                  m_adr_d = f_adr;
                  m_wre_d = f_wre;
                  m_dto_d = f_dto;
                  state_d = ST_BUSY_F;
               end
            end
         end
         ST_BUSY_F, ST_BUSY_G: begin
            if (m_ack) begin
               m_stb_d = 1'b0;
               m_wre_d = 1'b0;
               m_gnt_d = GNT_NONE;
               state_d = ST_ACK;
               if (state_q == ST_BUSY_F) begin
                  f_dti_d = m_dti;
                  f_ack_d = 1'b1;
               end else begin
                  g_dti_d = m_dti;
                  g_ack_d = 1'b1;
               end
            end
         end
         // one dead cycle so a held-over stb is seen as a fresh request
         ST_ACK: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         m_adr_q <= '0;
         m_dto_q <= '0;
         f_dti_q <= '0;
         g_dti_q <= '0;
         m_stb_q <= 1'b0;
         m_wre_q <= 1'b0;
         f_ack_q <= 1'b0;
         g_ack_q <= 1'b0;
         m_gnt_q <= GNT_NONE;
`ifdef DCPU16_ARB_RR_EN
         last_g_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         m_adr_q <= m_adr_d;
         m_dto_q <= m_dto_d;
         f_dti_q <= f_dti_d;
         g_dti_q <= g_dti_d;
         m_stb_q <= m_stb_d;
         m_wre_q <= m_wre_d;
         f_ack_q <= f_ack_d;
         g_ack_q <= g_ack_d;
         m_gnt_q <= m_gnt_d;
`ifdef DCPU16_ARB_RR_EN
         last_g_q <= last_g_d;
`endif
      end
   end

   assign m_adr = m_adr_q;
   assign m_dto = m_dto_q;
   assign m_stb = m_stb_q;
   assign m_wre = m_wre_q;
   assign m_gnt = m_gnt_q;
   assign f_dti = f_dti_q;
   assign g_dti = g_dti_q;
   assign f_ack = f_ack_q;
   assign g_ack = g_ack_q;

endmodule

// File: doc/dcpu16_arb.md
Name: dcpu16_arb

Overview:
Arbitrates the core's F-BUS and G-BUS (simplified Wishbone: adr/stb/wre/ack) onto a single-port memory bus.
- Sits between the memory-bus unit and the shared program/data RAM.
- Serialises requests and returns a one-cycle ack pulse to the owner, matching the core's stall rule (ena = stb XNOR ack).

Parameters:
AW, 16, address width
DW, 16, data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
f_adr  in  AW  F-BUS address
f_stb  in  1  F-BUS strobe/request
f_wre  in  1  F-BUS write enable
f_dto  in  DW  F-BUS write data
f_dti  out  DW  F-BUS read data
f_ack  out  1  F-BUS acknowledge pulse
g_adr  in  AW  G-BUS address
g_stb  in  1  G-BUS strobe/request
g_wre  in  1  G-BUS write enable
g_dto  in  DW  G-BUS write data
g_dti  out  DW  G-BUS read data
g_ack  out  1  G-BUS acknowledge pulse
m_adr  out  AW  memory address
m_stb  out  1  memory strobe
m_wre  out  1  memory write enable
m_dto  out  DW  memory write data
m_dti  in  DW  memory read data
m_ack  in  1  memory acknowledge
m_gnt  out  2  current owner: 00 none, 01 F, 10 G

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset values: state IDLE; m_adr, m_dto, f_dti, g_dti = 0; m_stb, m_wre, f_ack, g_ack = 0; m_gnt = 00; last-owner bit = G.
- All outputs registered.
- States: IDLE, BUSY_F, BUSY_G, ACK.
- IDLE:
  - Samples f_stb/g_stb. With no request, stay in IDLE.
  - Picks a winner and loads m_adr/m_wre/m_dto from it; sets m_stb=1 and m_gnt.
  - Moves to BUSY_F or BUSY_G. m_stb is visible the cycle after the request is sampled.
- BUSY_x:
  - Holds m_* stable until m_ack=1.
  - On m_ack: clear m_stb/m_wre; set m_gnt=00; capture m_dti into x_dti; set x_ack=1 for exactly one cycle (next cycle); move to ACK.
  - Requester stb/adr changes during BUSY are ignored.
- ACK: x_ack high this cycle only; return to IDLE unconditionally.
  - Guarantees a held-over stb is treated as a new request.
- Latency: stb sampled at cycle N -> m_stb at N+1; m_ack at cycle M -> x_ack and x_dti valid at M+1. Minimum request-to-ack is 2 cycles; back-to-back issue interval is 3 cycles.
- x_dti holds its last value until the next read ack; writes also update it from m_dti (don't-care data).
- m_ack while not in BUSY: ignored, no ack generated.
- Requester drops stb mid-BUSY (protocol violation): transaction still completes and ack is still pulsed.
- Simultaneous f_stb and g_stb in IDLE: resolved by the priority rule below. The loser is served on its next IDLE sample, provided its stb is still high.
- Reset mid-transaction: m_stb drops immediately (asynchronous); pending ack is lost; the requester reissues.
- No counters wrap; no internal queues.

Optional Feature:
DCPU16_ARB_RR_EN
- Defined: round-robin. On simultaneous requests, grant the requester not served last; the last-owner bit updates on every grant.
- Undefined: fixed priority, G-BUS over F-BUS always; the last-owner bit is not implemented.

Decomposition:
- dcpu16_pkg holds:
  - state encoding constants (IDLE=2'd0, BUSY_F=2'd1, BUSY_G=2'd2, ACK=2'd3)
  - owner codes (GNT_NONE=2'b00, GNT_F=2'b01, GNT_G=2'b10)
  - AW/DW defaults
- One sub-module, dcpu16_arb_pick: combinational winner select from (f_stb, g_stb, last_owner), with the RR/fixed choice inside it.

Test Plan:
- Single F read: f_stb=1, f_adr=0x0010; memory acks 1 cycle after m_stb with 0xBEEF -> m_adr=0x0010, m_gnt=01, f_ack one-cycle pulse, f_dti=0xBEEF, g_ack stays 0.
- Single G write: g_stb=1, g_wre=1, g_adr=0x8000, g_dto=0x1234 -> m_wre=1, m_dto=0x1234, m_adr=0x8000, single g_ack pulse.
- Simultaneous requests, fixed priority: f_stb=g_stb=1 (F 0x0001, G 0x0002) -> G served first (m_adr=0x0002), then F (m_adr=0x0001).
  - With DCPU16_ARB_RR_EN and last owner G: F is served first.
- Memory wait states: m_ack delayed 5 cycles -> m_stb/m_adr stable for all 5 cycles, no requester ack until the cycle after m_ack.
- Held stb: F keeps stb=1 across its ack with new adr 0x0011 -> two distinct memory transactions, 3 cycles apart, two ack pulses.
- Reset mid-BUSY: assert rst while m_stb=1 -> m_stb, m_gnt and acks cleared asynchronously; after release, state is IDLE and a stray m_ack produces no ack.
